// File: rtl/demux_channel_sequencer.sv
// Round-robin channel sequencer feeding a 1-to-8 bit demux from a valid/ready serial stream.
// Optional one-cycle guard state after each channel advance: define SEQ_GAP_EN.
module demux_channel_sequencer #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned DWELL  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       frame_start,
   input  logic       in_valid,
   input  logic       in_data,
   output logic       in_ready,
   output logic       dmx_in,
   output logic [3:0] dmx_sel,
   output logic       dmx_valid,
   output logic       frame_done,
   output logic [2:0] ch_active
);

`ifdef SEQ_GAP_EN
   typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;
`else
   typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

   localparam logic [2:0] LastCh  = 3'(NUM_CH - 1);
   localparam logic [7:0] LastBit = 8'(DWELL - 1);

   state_e     state_q, state_d;
   logic [2:0] ch_q, ch_d;
   logic [7:0] bit_q, bit_d;
   logic       dmx_in_q, dmx_in_d;
   logic [2:0] dmx_sel_q, dmx_sel_d;
   logic       dmx_valid_q, dmx_valid_d;
   logic       frame_done_q, frame_done_d;
   logic       in_ready_q, in_ready_d;

   logic       accept;
   logic       advance;
   logic [2:0] ch_base;
   logic [7:0] bit_base;

   assign accept = in_valid & in_ready_q;

   always_comb begin
      // frame_start clears the counters before the same-cycle accept is routed
      ch_base      = frame_start ? 3'd0 : ch_q;
      bit_base     = frame_start ? 8'd0 : bit_q;
      ch_d         = ch_base;
      bit_d        = bit_base;
      advance      = 1'b0;
      frame_done_d = 1'b0;
      dmx_valid_d  = accept;
      dmx_in_d     = accept & in_data;
      dmx_sel_d    = accept ? ch_base : dmx_sel_q;
      if (accept) begin
         if (bit_base == LastBit) begin
            bit_d   = 8'd0;
            advance = 1'b1;
            if (ch_base == LastCh) begin
               ch_d         = 3'd0;
               frame_done_d = 1'b1;
            end else begin
               ch_d = ch_base + 3'd1;
            end
         end else begin
            bit_d = bit_base + 8'd1;
         end
      end

      state_d = state_q;
      case (state_q)
         StIdle: state_d = enable ? StRun : StIdle;
         StRun: begin
            state_d = enable ? StRun : StIdle;
`ifdef SEQ_GAP_EN
            if (advance) state_d = StGap;
`endif
         end
`ifdef SEQ_GAP_EN
         StGap: state_d = enable ? StRun : StIdle;
`endif
         default: state_d = StIdle;
      endcase
      in_ready_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ch_q         <= 3'd0;
         bit_q        <= 8'd0;
         dmx_in_q     <= 1'b0;
         dmx_sel_q    <= 3'd0;
         dmx_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         bit_q        <= bit_d;
         dmx_in_q     <= dmx_in_d;
         dmx_sel_q    <= dmx_sel_d;
         dmx_valid_q  <= dmx_valid_d;
         frame_done_q <= frame_done_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign dmx_in     = dmx_in_q;
   assign dmx_sel    = {1'b0, dmx_sel_q};
   assign dmx_valid  = dmx_valid_q;
   assign frame_done = frame_done_q;
   assign ch_active  = ch_q;

endmodule

// File: tb/tb_demux_channel_sequencer.sv
// Directed bench for demux_channel_sequencer with NUM_CH=8, DWELL=2 (default build, no guard cycle).
module tb_demux_channel_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       frame_start;
   logic       in_valid;
   logic       in_data;
   logic       in_ready;
   logic       dmx_in;
   logic [3:0] dmx_sel;
   logic       dmx_valid;
   logic       frame_done;
   logic [2:0] ch_active;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   demux_channel_sequencer #(
      .NUM_CH(8),
      .DWELL (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .frame_start(frame_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .dmx_in     (dmx_in),
      .dmx_sel    (dmx_sel),
      .dmx_valid  (dmx_valid),
      .frame_done (frame_done),
      .ch_active  (ch_active)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_routed(input string tag, input logic v, input logic d, input logic [3:0] s,
                               input logic fd);
      check({tag, ".valid"}, 8'(dmx_valid), 8'(v));
      check({tag, ".in"}, 8'(dmx_in), 8'(d));
      check({tag, ".sel"}, 8'(dmx_sel), 8'(s));
      check({tag, ".done"}, 8'(frame_done), 8'(fd));
   endtask

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      frame_start = 1'b0;
      in_valid    = 1'b0;
      in_data     = 1'b0;
      #1;
      check("rst.ready", 8'(in_ready), 8'd0);
      check_routed("rst", 1'b0, 1'b0, 4'd0, 1'b0);
      check("rst.ch", 8'(ch_active), 8'd0);

      tick();
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      check("rel.ready0", 8'(in_ready), 8'd0);
      tick();
      check("rel.ready1", 8'(in_ready), 8'd1);
      check("rel.ch", 8'(ch_active), 8'd0);

      // Full frame: 16 ones, sel 0,0,1,1,...,7,7; frame_done only on the last.
      in_valid = 1'b1;
      in_data  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check_routed($sformatf("frame%0d", i), 1'b1, 1'b1, 4'(i / 2), (i == 15));
      end
      in_valid = 1'b0;
      check("frame.wrap_ch", 8'(ch_active), 8'd0);

      // in_valid 1,0,1,0: dmx_in forced to 0 and sel held on idle cycles.
      in_valid = 1'b1; in_data = 1'b1;
      tick();
      check_routed("gap0", 1'b1, 1'b1, 4'd0, 1'b0);
      in_valid = 1'b0; in_data = 1'b1;
      tick();
      check_routed("gap1", 1'b0, 1'b0, 4'd0, 1'b0);
      in_valid = 1'b1; in_data = 1'b0;
      tick();
      check_routed("gap2", 1'b1, 1'b0, 4'd0, 1'b0);
      in_valid = 1'b0; in_data = 1'b1;
      tick();
      check_routed("gap3", 1'b0, 1'b0, 4'd0, 1'b0);
      check("gap.ch", 8'(ch_active), 8'd1);

      // frame_start without accept resets counters.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("fs_idle.ch", 8'(ch_active), 8'd0);
      check("fs_idle.valid", 8'(dmx_valid), 8'd0);

      // Enable drop with the third bit; fourth bit lands on channel 1 after re-enable.
      in_valid = 1'b1; in_data = 1'b1;
      tick();
      check_routed("en0", 1'b1, 1'b1, 4'd0, 1'b0);
      in_data = 1'b0;
      tick();
      check_routed("en1", 1'b1, 1'b0, 4'd0, 1'b0);
      in_data = 1'b1;
      enable  = 1'b0;
      tick();
      check_routed("en2", 1'b1, 1'b1, 4'd1, 1'b0);
      in_data = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("off%0d.ready", i), 8'(in_ready), 8'd0);
         tick();
         check_routed($sformatf("off%0d", i), 1'b0, 1'b0, 4'd1, 1'b0);
      end
      enable = 1'b1;
      tick();
      check_routed("reen", 1'b0, 1'b0, 4'd1, 1'b0);
      check("reen.ready", 8'(in_ready), 8'd1);
      tick();
      check_routed("en3", 1'b1, 1'b0, 4'd1, 1'b0);
      check("en3.ch", 8'(ch_active), 8'd2);

      // Advance to ch=5, bit=1 then restart with frame_start on an accept.
      for (int i = 0; i < 7; i++) tick();
      check("pre_fs.ch", 8'(ch_active), 8'd5);
      frame_start = 1'b1;
      in_data     = 1'b1;
      tick();
      check_routed("fs0", 1'b1, 1'b1, 4'd0, 1'b0);
      check("fs0.ch", 8'(ch_active), 8'd0);
      frame_start = 1'b0;
      in_data     = 1'b0;
      tick();
      check_routed("fs1", 1'b1, 1'b0, 4'd0, 1'b0);
      check("fs1.ch", 8'(ch_active), 8'd1);

      // Asynchronous reset mid-stream.
      in_data = 1'b1;
      tick();
      check_routed("pre_rst", 1'b1, 1'b1, 4'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst.ready", 8'(in_ready), 8'd0);
      check_routed("mrst", 1'b0, 1'b0, 4'd0, 1'b0);
      check("mrst.ch", 8'(ch_active), 8'd0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("mrst.ready1", 8'(in_ready), 8'd1);
      check("mrst.ch1", 8'(ch_active), 8'd0);
      check("mrst.done", 8'(frame_done), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
